// File: rtl/candidate_buffer.sv
// Slot buffer: writes fill the lowest free slot, occupancy is exported as a candidate
// bitmask, and a selected slot is released through a registered valid/ready output.
module candidate_buffer #(
  parameter int bs = 16,
  parameter int DW = 32,
  localparam int IW = $clog2(bs),
  localparam int CW = $clog2(bs) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [bs-1:0] cand_list,
  input  logic          sel_valid,
  input  logic [IW-1:0] sel_index,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          sel_err
);

  logic [bs-1:0] occ_q, occ_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          sel_err_q, sel_err_d;
  logic [DW-1:0] mem_q [bs];

  logic [IW-1:0] wr_idx;
  logic          write_fire, sel_fire, rel_fire;

  assign full      = (count_q == CW'(bs));
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign cand_list = occ_q;
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel_err   = sel_err_q;

  // Downward scan so the last hit is the lowest free slot.
  always_comb begin
    wr_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (!occ_q[i]) wr_idx = IW'(i);
    end
  end

  always_comb begin
    write_fire  = in_valid & in_ready;
    sel_fire    = sel_valid & (~out_valid_q | out_ready);
    rel_fire    = sel_fire & occ_q[sel_index];
    occ_d       = occ_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sel_err_d   = sel_fire & ~occ_q[sel_index];
    // Write target is free and release target is occupied, so they never collide.
    if (write_fire) occ_d[wr_idx] = 1'b1;
    if (rel_fire) begin
      occ_d[sel_index] = 1'b0;
      out_valid_d      = 1'b1;
      out_data_d       = mem_q[sel_index];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    count_d = count_q + CW'(write_fire) - CW'(rel_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Slot storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst && write_fire) mem_q[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_candidate_buffer.sv
// Randomised and directed bench for candidate_buffer against a slot-array reference model.
module tb_candidate_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [15:0] cand_list;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel_index = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        full, empty, sel_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit [15:0]   m_occ;
  logic [31:0] m_mem [16];
  bit          m_vld, m_err;
  logic [31:0] m_data;

  candidate_buffer #(.bs(16), .DW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cand_list(cand_list), .sel_valid(sel_valid), .sel_index(sel_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [57:0] obs_vec();
    return {cand_list, count, out_valid, out_data, sel_err, full, empty, in_ready};
  endfunction

  function automatic logic [57:0] exp_vec();
    int c;
    c = $countones(m_occ);
    return {m_occ, 5'(c), m_vld, m_data, m_err, c == 16, c == 0, c != 16};
  endfunction

  task automatic model_step();
    int c;
    int idx;
    bit wf, sf;
    bit [15:0] nocc;
    if (!rst) begin
      m_occ = '0; m_vld = 0; m_data = '0; m_err = 0;
      return;
    end
    c    = $countones(m_occ);
    wf   = in_valid && (c < 16);
    sf   = sel_valid && (!m_vld || out_ready);
    nocc = m_occ;
    if (wf) begin
      idx = 0;
      while (m_occ[idx]) idx++;
      nocc[idx]  = 1'b1;
      m_mem[idx] = in_data;
    end
    m_err = sf && !m_occ[sel_index];
    if (sf && m_occ[sel_index]) begin
      m_data = m_mem[sel_index];
      m_vld  = 1;
      nocc[sel_index] = 1'b0;
    end else if (out_ready) begin
      m_vld = 0;
    end
    m_occ = nocc;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; in_valid = 1'b0; sel_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; sel_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state got %h want %h", obs_vec(), exp_vec());
    end
    n_tests++;
    if ({cand_list, count, out_valid, out_data, sel_err, empty, in_ready} !== {16'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL reset_const cand=%h cnt=%0d ov=%b od=%h", cand_list, count, out_valid, out_data);
    end
    idle();
  endtask

  task automatic test_write_basic(output logic [31:0] b_val);
    idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      if (i == 1) b_val = in_data;
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL write_%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    idle();
    n_tests++;
    if ({cand_list, count, empty} !== {16'h0007, 5'd3, 1'b0}) begin
      n_fail++; $display("FAIL write_abc cand=%h cnt=%0d empty=%b want 0007/3/0", cand_list, count, empty);
    end
  endtask

  task automatic test_select(input logic [31:0] b_val);
    idle();
    sel_valid = 1'b1; sel_index = 4'd1;
    tick();
    sel_valid = 1'b0;
    n_tests++;
    if ({out_valid, out_data, cand_list} !== {1'b1, b_val, 16'h0005}) begin
      n_fail++; $display("FAIL select_b ov=%b od=%h cand=%h want 1/%h/0005", out_valid, out_data, cand_list, b_val);
    end
    in_valid = 1'b1; in_data = $urandom;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({cand_list, count, out_valid} !== {16'h0007, 5'd3, 1'b0} || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL refill_slot1 got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_full();
    idle();
    while ($countones(m_occ) < 16) begin
      in_valid = 1'b1; in_data = $urandom;
      tick();
    end
    n_tests++;
    if ({full, in_ready, count, cand_list} !== {1'b1, 1'b0, 5'd16, 16'hffff}) begin
      n_fail++; $display("FAIL full_flags full=%b rdy=%b cnt=%0d cand=%h", full, in_ready, count, cand_list);
    end
    in_data = 32'hdead_beef;
    tick();
    n_tests++;
    if (obs_vec() !== exp_vec() || count !== 5'd16) begin
      n_fail++; $display("FAIL full_ignore got %h want %h", obs_vec(), exp_vec());
    end
    sel_valid = 1'b1; sel_index = 4'd7;
    tick();
    sel_valid = 1'b0; in_valid = 1'b0;
    n_tests++;
    if ({in_ready, full, count, out_valid} !== {1'b1, 1'b0, 5'd15, 1'b1} || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL full_release got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_simul();
    test_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      tick();
    end
    in_data = $urandom; sel_valid = 1'b1; sel_index = 4'd0;
    tick();
    idle();
    n_tests++;
    if ({cand_list, count} !== {16'h001e, 5'd4} || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL simul_wr_rel got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    test_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; sel_valid = 1'b1; sel_index = 4'd0;
    tick();
    held = m_mem[0];
    sel_index = 4'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({out_valid, out_data, sel_err, cand_list} !== {1'b1, held, 1'b0, 16'h0002}) begin
        n_fail++; $display("FAIL stall_%0d ov=%b od=%h err=%b cand=%h want od %h", i, out_valid, out_data, sel_err, cand_list, held);
      end
    end
    out_ready = 1'b1; sel_index = 4'd9;
    tick();
    sel_valid = 1'b0;
    n_tests++;
    if ({sel_err, cand_list, out_valid} !== {1'b1, 16'h0002, 1'b0} || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL sel_err_pulse got %h want %h", obs_vec(), exp_vec());
    end
    tick();
    n_tests++;
    if (sel_err !== 1'b0) begin
      n_fail++; $display("FAIL sel_err_clear got %b want 0", sel_err);
    end
  endtask

  task automatic test_reset_midflight();
    test_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; sel_valid = 1'b1; sel_index = 4'd3;
    tick();
    sel_valid = 1'b0;
    n_tests++;
    if ({out_valid, count} !== {1'b1, 5'd5}) begin
      n_fail++; $display("FAIL pre_reset ov=%b cnt=%0d want 1/5", out_valid, count);
    end
    rst = 1'b0; in_valid = 1'b1; in_data = $urandom;
    tick();
    n_tests++;
    if ({cand_list, count, out_valid, out_data, sel_err, empty} !== {16'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_midflight got %h want all-reset", obs_vec());
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(99) >= 2);
      in_valid  = ($urandom_range(99) < 55);
      in_data   = $urandom;
      sel_valid = ($urandom_range(99) < 50);
      sel_index = 4'($urandom_range(15));
      out_ready = ($urandom_range(99) < 70);
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    logic [31:0] b_val;
    test_reset();
    test_write_basic(b_val);
    test_select(b_val);
    test_full();
    test_simul();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
